// File: rtl/mre_pkg.sv
// Shared types and helpers for the FIR approximate-adder error monitor.
//   state_t  : monitor FSM states
//   W_DEF / FRAC_DEF / NSAMP_DEF / ACC_W_DEF : default parameter values
//   sat_add  : unsigned add clamped to a w-bit all-ones ceiling (w <= 63)
package mre_pkg;

  localparam int W_DEF     = 16;
  localparam int FRAC_DEF  = 8;
  localparam int NSAMP_DEF = 1024;
  localparam int ACC_W_DEF = 32;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCEPT = 2'd1,
    DIVIDE = 2'd2,
    DONE   = 2'd3
  } state_t;

  // Operands are carried at 64 bits so one helper serves any accumulator
  // width; the sum cannot wrap because both inputs are below 2^63.
  function automatic logic [63:0] sat_add(input logic [63:0] acc,
                                          input logic [63:0] inc,
                                          input int unsigned w = ACC_W_DEF);
    logic [63:0] lim;
    logic [63:0] sum;
    lim = (64'd1 << w) - 64'd1;
    sum = acc + inc;
    return (sum > lim) ? lim : sum;
  endfunction

endpackage

// File: rtl/mre_divider.sv
// Sequential restoring divider, one quotient bit per cycle.
//   clk, rstN : clock, async active-low reset
//   go        : load dividend/divisor and start (single-cycle pulse)
//   dividend  : W+1+FRAC-bit unsigned numerator
//   divisor   : W+1-bit unsigned denominator, must be non-zero
//   quotient  : floor(dividend/divisor), valid only while q_valid is high
//   q_valid   : high during the N-th (final) iteration cycle after go
// The final quotient bit is presented combinationally on the last cycle so
// the consumer can accumulate it without an extra cycle of latency.
module mre_divider #(
  parameter int W    = 16,
  parameter int FRAC = 8
) (
  input  logic            clk,
  input  logic            rstN,
  input  logic            go,
  input  logic [W+FRAC:0] dividend,
  input  logic [W:0]      divisor,
  output logic [W+FRAC:0] quotient,
  output logic            q_valid
);

  localparam int N  = W + 1 + FRAC;
  localparam int CW = $clog2(N);

  logic [W:0]    rem_q;
  logic [W:0]    dsr_q;
  logic [N-1:0]  dq_q;     // dividend bits shift out, quotient bits shift in
  logic [CW-1:0] cnt_q;
  logic          run_q;

  logic [W+1:0]  trial;
  logic [W+1:0]  diff;
  logic          fits;

  // trial < 2*divisor, so trial - divisor lies in [-divisor, divisor-1];
  // its top bit is therefore a clean borrow flag.
  always_comb begin
    trial = {rem_q, dq_q[N-1]};
    diff  = trial - {1'b0, dsr_q};
    fits  = ~diff[W+1];
  end

  assign quotient = {dq_q[N-2:0], fits};
  assign q_valid  = run_q && (cnt_q == CW'(N-1));

  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      rem_q <= '0;
      dsr_q <= '0;
      dq_q  <= '0;
      cnt_q <= '0;
      run_q <= 1'b0;
    end else if (go) begin
      rem_q <= '0;
      dsr_q <= divisor;
      dq_q  <= dividend;
      cnt_q <= '0;
      run_q <= 1'b1;
    end else if (run_q) begin
      rem_q <= fits ? diff[W:0] : trial[W:0];
      dq_q  <= quotient;
      cnt_q <= cnt_q + CW'(1);
      if (q_valid) run_q <= 1'b0;
    end
  end

endmodule

// File: rtl/fir_mre_monitor.sv
// Error monitor for the exact/approximate FIR pair.
// Accumulates, over NSAMP accepted pairs, sum and max of |y_exact-y_approx|,
// the sum of floor((|e| << FRAC) / |y_exact|) and the count of y_exact == 0.
//   clk, rstN          : clock, async active-low reset (aborts a run)
//   start              : begin a run (honoured only in IDLE)
//   in_valid/in_ready  : sample-pair handshake
//   y_exact, y_approx  : signed W-bit samples
//   busy, done         : run status; done pulses once per completed run
//   sample_cnt, zero_ref_cnt, sum_abs_err, max_abs_err, sum_rel_err : results
module fir_mre_monitor
  import mre_pkg::*;
#(
  parameter int W     = W_DEF,
  parameter int FRAC  = FRAC_DEF,
  parameter int NSAMP = NSAMP_DEF,
  parameter int ACC_W = ACC_W_DEF,
  parameter int CNT_W = $clog2(NSAMP + 1)
) (
  input  logic             clk,
  input  logic             rstN,
  input  logic             start,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [W-1:0]     y_exact,
  input  logic [W-1:0]     y_approx,
  output logic             busy,
  output logic             done,
  output logic [CNT_W-1:0] sample_cnt,
  output logic [CNT_W-1:0] zero_ref_cnt,
  output logic [ACC_W-1:0] sum_abs_err,
  output logic [W:0]       max_abs_err,
  output logic [ACC_W-1:0] sum_rel_err
);

  localparam logic [W:0] ONE = (W+1)'(1);

  state_t state_q, state_d;

  logic [W:0]      ex, ap, e;
  logic [W:0]      abs_e, abs_x;
  logic            zero_ref, no_div, last, go, q_valid;
  logic [W+FRAC:0] quotient;

  // Sign-extend to W+1 bits so the difference and |-2^(W-1)| both fit.
  always_comb begin
    ex       = {y_exact[W-1], y_exact};
    ap       = {y_approx[W-1], y_approx};
    e        = ex - ap;
    abs_e    = e[W]  ? (~e  + ONE) : e;
    abs_x    = ex[W] ? (~ex + ONE) : ex;
    zero_ref = (y_exact == '0);
    no_div   = zero_ref || (abs_e == '0);
    last     = (sample_cnt == CNT_W'(NSAMP - 1));
  end

  assign in_ready = (state_q == ACCEPT);
  assign busy     = (state_q == ACCEPT) || (state_q == DIVIDE);
  assign done     = (state_q == DONE);

  mre_divider #(.W(W), .FRAC(FRAC)) u_div (
    .clk      (clk),
    .rstN     (rstN),
    .go       (go),
    .dividend ({abs_e, {FRAC{1'b0}}}),
    .divisor  (abs_x),
    .quotient (quotient),
    .q_valid  (q_valid)
  );

  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) state_q <= IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    go      = 1'b0;
    case (state_q)
      IDLE:   if (start) state_d = ACCEPT;
      ACCEPT: if (in_valid) begin
        if (no_div) begin
          state_d = last ? DONE : ACCEPT;
        end else begin
          state_d = DIVIDE;
          go      = 1'b1;
        end
      end
      DIVIDE: if (q_valid) state_d = last ? DONE : ACCEPT;
      DONE:   state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      sample_cnt   <= '0;
      zero_ref_cnt <= '0;
      sum_abs_err  <= '0;
      max_abs_err  <= '0;
      sum_rel_err  <= '0;
    end else begin
      case (state_q)
        IDLE: if (start) begin
          sample_cnt   <= '0;
          zero_ref_cnt <= '0;
          sum_abs_err  <= '0;
          max_abs_err  <= '0;
          sum_rel_err  <= '0;
        end
        ACCEPT: if (in_valid) begin
          sum_abs_err <= ACC_W'(sat_add(64'(sum_abs_err), 64'(abs_e), ACC_W));
          if (abs_e > max_abs_err) max_abs_err <= abs_e;
          if (zero_ref) begin
            zero_ref_cnt <= zero_ref_cnt + CNT_W'(1);
            sample_cnt   <= sample_cnt + CNT_W'(1);
          end else if (abs_e == '0) begin
            sample_cnt <= sample_cnt + CNT_W'(1);
          end
        end
        DIVIDE: if (q_valid) begin
          sum_rel_err <= ACC_W'(sat_add(64'(sum_rel_err), 64'(quotient), ACC_W));
          sample_cnt  <= sample_cnt + CNT_W'(1);
        end
        default: ;
      endcase
    end
  end

endmodule
